// File: rtl/hci_core_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : hci_core_rr_arbiter
//  Purpose  : N-to-1 round-robin arbiter sharing one TCDM master port between
//             NB_IN HCI core requesters. Issued requester IDs are held in an
//             in-order queue so each response is routed back to its issuer.
//  Ports    : clk_i / rst_i / clear_i       clock, sync reset, sync soft clear
//             in_req_i .. in_user_i         per-requester request + payload
//             in_gnt_o                      per-requester grant
//             in_r_valid_o / in_r_data_o /  response routed to owner, data and
//             in_r_user_o / in_lrdy_i       user broadcast, owner backpressure
//             out_req_o .. out_user_o       muxed master request + payload
//             out_gnt_i                     master grant
//             out_r_valid_i / out_r_data_i /
//             out_r_user_i / out_lrdy_o     master response + response ready
//             outstanding_o                 ID-queue occupancy
//             err_o                         sticky "response with no owner"
//  Revision : 1.0  initial release
// ============================================================================
module hci_core_rr_arbiter #(
  parameter int NB_IN           = 4,
  parameter int AW              = 32,
  parameter int DW              = 32,
  parameter int BW              = 8,
  parameter int UW              = 1,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     clear_i,
  input  logic [NB_IN-1:0]                         in_req_i,
  output logic [NB_IN-1:0]                         in_gnt_o,
  input  logic [NB_IN*AW-1:0]                      in_add_i,
  input  logic [NB_IN-1:0]                         in_wen_i,
  input  logic [NB_IN*DW-1:0]                      in_data_i,
  input  logic [NB_IN*(DW/BW)-1:0]                 in_be_i,
  input  logic [NB_IN*UW-1:0]                      in_user_i,
  output logic [NB_IN-1:0]                         in_r_valid_o,
  output logic [DW-1:0]                            in_r_data_o,
  output logic [UW-1:0]                            in_r_user_o,
  input  logic [NB_IN-1:0]                         in_lrdy_i,
  output logic                                     out_req_o,
  input  logic                                     out_gnt_i,
  output logic [AW-1:0]                            out_add_o,
  output logic                                     out_wen_o,
  output logic [DW-1:0]                            out_data_o,
  output logic [DW/BW-1:0]                         out_be_o,
  output logic [UW-1:0]                            out_user_o,
  input  logic                                     out_r_valid_i,
  input  logic [DW-1:0]                            out_r_data_i,
  input  logic [UW-1:0]                            out_r_user_i,
  output logic                                     out_lrdy_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding_o,
  output logic                                     err_o
);

  localparam int c_BEW = DW / BW;
  localparam int c_IDW = $clog2(NB_IN);
  localparam int c_OCW = $clog2(MAX_OUTSTANDING + 1);
  localparam int c_QAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  // Arbitration state
  logic [c_IDW-1:0] r_rr_ptr;
  logic             r_lock_vld;
  logic [c_IDW-1:0] r_lock_idx;

  // Requester-ID queue
  logic [c_IDW-1:0] r_id_q [MAX_OUTSTANDING];
  logic [c_QAW-1:0] r_wptr;
  logic [c_QAW-1:0] r_rptr;
  logic [c_OCW-1:0] r_count;
  logic             r_err;

  logic [c_IDW-1:0] w_hi_sel;
  logic [c_IDW-1:0] w_lo_sel;
  logic             w_hi_hit;
  logic [c_IDW-1:0] w_rr_sel;
  logic [c_IDW-1:0] w_sel;
  logic [c_IDW-1:0] w_sel_inc;
  logic [c_IDW-1:0] w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_grant;
  logic             w_pop;
  logic             w_rsp_route;

  function automatic logic [c_QAW-1:0] f_qinc(input logic [c_QAW-1:0] p);
    if (p == c_QAW'(MAX_OUTSTANDING - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  // Round-robin pick: the lowest requesting index at or above the pointer
  // wins (w_hi_sel); if none exists the search wraps to the lowest requesting
  // index overall (w_lo_sel). Scanning downward lets the last hit stand.
  always_comb begin
    w_hi_sel = '0;
    w_lo_sel = r_rr_ptr;
    w_hi_hit = 1'b0;
    for (int i = NB_IN - 1; i >= 0; i--) begin
      if (in_req_i[i]) begin
        w_lo_sel = c_IDW'(i);
        if (c_IDW'(i) >= r_rr_ptr) begin
          w_hi_sel = c_IDW'(i);
          w_hi_hit = 1'b1;
        end
      end
    end
  end

  assign w_rr_sel  = w_hi_hit ? w_hi_sel : w_lo_sel;
  // A pending, ungranted request keeps its requester selected so the master
  // sees a stable request until it grants.
  assign w_sel     = r_lock_vld ? r_lock_idx : w_rr_sel;
  assign w_sel_inc = (w_sel == c_IDW'(NB_IN - 1)) ? '0 : w_sel + 1'b1;

  assign w_full    = (r_count == c_OCW'(MAX_OUTSTANDING));
  assign w_empty   = (r_count == '0);
  assign w_head    = r_id_q[r_rptr];

  // Full blocks new requests even if a response frees a slot this cycle;
  // this keeps the grant path independent of the response path.
  assign out_req_o = (|in_req_i) & ~w_full;
  assign w_grant   = out_req_o & out_gnt_i;
  assign in_gnt_o  = w_grant ? (NB_IN'(1) << w_sel) : '0;

  assign out_add_o  = in_add_i[int'(w_sel)*AW +: AW];
  assign out_wen_o  = in_wen_i[w_sel];
  assign out_data_o = in_data_i[int'(w_sel)*DW +: DW];
  assign out_be_o   = in_be_i[int'(w_sel)*c_BEW +: c_BEW];
  assign out_user_o = in_user_i[int'(w_sel)*UW +: UW];

  // Responses with an empty queue have no owner: they are not routed and
  // only raise the error flag (a push in the same cycle does not help).
  assign w_rsp_route  = out_r_valid_i & ~w_empty;
  assign out_lrdy_o   = w_empty ? 1'b1 : in_lrdy_i[w_head];
  assign w_pop        = w_rsp_route & out_lrdy_o;
  assign in_r_valid_o = w_rsp_route ? (NB_IN'(1) << w_head) : '0;
  assign in_r_data_o  = out_r_data_i;
  assign in_r_user_o  = out_r_user_i;

  assign outstanding_o = r_count;
  assign err_o         = r_err;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_rr_ptr   <= '0;
      r_lock_vld <= 1'b0;
      r_lock_idx <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_grant) begin
        r_rr_ptr <= w_sel_inc;
      end

      if (out_gnt_i) begin
        r_lock_vld <= 1'b0;
      end else if (out_req_o) begin
        r_lock_vld <= 1'b1;
        r_lock_idx <= w_sel;
      end

      if (w_grant) begin
        r_wptr <= f_qinc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= f_qinc(r_rptr);
      end

      if (w_grant && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_grant) begin
        r_count <= r_count - 1'b1;
      end

      if (out_r_valid_i && w_empty) begin
        r_err <= 1'b1;
      end
    end
  end

  // Queue storage needs no reset: entries are only read while occupied.
  always_ff @(posedge clk_i) begin
    if (w_grant) begin
      r_id_q[r_wptr] <= w_sel;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hci_core_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_hci_core_rr_arbiter
//  Purpose  : Directed bench for hci_core_rr_arbiter; expected grants and
//             responses are queued by the driver and checked by a monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hci_core_rr_arbiter;

  localparam int NB_IN = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BW    = 8;
  localparam int UW    = 1;
  localparam int MO    = 4;
  localparam int OCW   = $clog2(MO + 1);

  logic                    clk_i = 1'b0;
  logic                    rst_i;
  logic                    clear_i;
  logic [NB_IN-1:0]        in_req_i;
  logic [NB_IN-1:0]        in_gnt_o;
  logic [NB_IN*AW-1:0]     in_add_i;
  logic [NB_IN-1:0]        in_wen_i;
  logic [NB_IN*DW-1:0]     in_data_i;
  logic [NB_IN*(DW/BW)-1:0] in_be_i;
  logic [NB_IN*UW-1:0]     in_user_i;
  logic [NB_IN-1:0]        in_r_valid_o;
  logic [DW-1:0]           in_r_data_o;
  logic [UW-1:0]           in_r_user_o;
  logic [NB_IN-1:0]        in_lrdy_i;
  logic                    out_req_o;
  logic                    out_gnt_i;
  logic [AW-1:0]           out_add_o;
  logic                    out_wen_o;
  logic [DW-1:0]           out_data_o;
  logic [DW/BW-1:0]        out_be_o;
  logic [UW-1:0]           out_user_o;
  logic                    out_r_valid_i;
  logic [DW-1:0]           out_r_data_i;
  logic [UW-1:0]           out_r_user_i;
  logic                    out_lrdy_o;
  logic [OCW-1:0]          outstanding_o;
  logic                    err_o;

  hci_core_rr_arbiter #(
    .NB_IN(NB_IN), .AW(AW), .DW(DW), .BW(BW), .UW(UW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
    .in_req_i(in_req_i), .in_gnt_o(in_gnt_o), .in_add_i(in_add_i),
    .in_wen_i(in_wen_i), .in_data_i(in_data_i), .in_be_i(in_be_i),
    .in_user_i(in_user_i), .in_r_valid_o(in_r_valid_o),
    .in_r_data_o(in_r_data_o), .in_r_user_o(in_r_user_o),
    .in_lrdy_i(in_lrdy_i), .out_req_o(out_req_o), .out_gnt_i(out_gnt_i),
    .out_add_o(out_add_o), .out_wen_o(out_wen_o), .out_data_o(out_data_o),
    .out_be_o(out_be_o), .out_user_o(out_user_o),
    .out_r_valid_i(out_r_valid_i), .out_r_data_i(out_r_data_i),
    .out_r_user_i(out_r_user_i), .out_lrdy_o(out_lrdy_o),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { int idx; logic [31:0] add; } gnt_exp_t;
  typedef struct { logic [3:0] vec; logic [31:0] data; } rsp_exp_t;

  gnt_exp_t q_gnt[$];
  rsp_exp_t q_rsp[$];
  int n_vec  = 0;
  int n_fail = 0;

  function automatic logic [31:0] addr_of(input int i);
    return 32'hA000_0000 + 32'(i) * 32'h10;
  endfunction

  function automatic logic [3:0] oh(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return one << i;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One bus cycle: queue the expectations for this cycle, then drive.
  // Returns just after the falling edge so callers can check outputs.
  task automatic cyc(input logic [3:0] req, input logic gnt, input logic rv,
                     input logic [31:0] rd, input logic [3:0] lrdy,
                     input int eg, input logic [3:0] erv, input logic [31:0] erd);
    gnt_exp_t g;
    rsp_exp_t r;
    @(posedge clk_i);
    #1;
    if (eg >= 0) begin
      g.idx = eg;
      g.add = addr_of(eg);
      q_gnt.push_back(g);
    end
    if (erv != 4'b0) begin
      r.vec  = erv;
      r.data = erd;
      q_rsp.push_back(r);
    end
    in_req_i      = req;
    out_gnt_i     = gnt;
    out_r_valid_i = rv;
    out_r_data_i  = rd;
    out_r_user_i  = rd[0];
    in_lrdy_i     = lrdy;
    @(negedge clk_i);
    #1;
  endtask

  task automatic pulse(input logic is_clear);
    @(posedge clk_i);
    #1;
    in_req_i = '0; out_gnt_i = 1'b0; out_r_valid_i = 1'b0;
    if (is_clear) clear_i = 1'b1; else rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    clear_i = 1'b0;
    rst_i   = 1'b0;
    @(negedge clk_i);
    #1;
  endtask

  // Monitor: compare every grant and every accepted response in order.
  always @(negedge clk_i) begin
    gnt_exp_t g;
    rsp_exp_t r;
    if (!rst_i) begin
      if (out_req_o && out_gnt_i) begin
        if (q_gnt.size() == 0) begin
          chk("grant_unexpected", {28'b0, in_gnt_o}, 32'h0);
        end else begin
          g = q_gnt.pop_front();
          chk("grant_vec", {28'b0, in_gnt_o}, {28'b0, oh(g.idx)});
          chk("grant_add", out_add_o, g.add);
        end
      end
      if ((|in_r_valid_o) && out_lrdy_o) begin
        if (q_rsp.size() == 0) begin
          chk("rsp_unexpected", {28'b0, in_r_valid_o}, 32'h0);
        end else begin
          r = q_rsp.pop_front();
          chk("rsp_vec", {28'b0, in_r_valid_o}, {28'b0, r.vec});
          chk("rsp_data", in_r_data_o, r.data);
          chk("rsp_user", {31'b0, in_r_user_o}, {31'b0, r.data[0]});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; in_req_i = '0; out_gnt_i = 1'b0;
    out_r_valid_i = 1'b0; out_r_data_i = '0; out_r_user_i = '0; in_lrdy_i = '1;
    in_wen_i = 4'b0101;
    for (int i = 0; i < NB_IN; i++) begin
      in_add_i[i*AW +: AW]   = addr_of(i);
      in_data_i[i*DW +: DW]  = 32'h5A00_0000 + 32'(i);
      in_be_i[i*4 +: 4]      = 4'(i + 1);
      in_user_i[i]           = i[0];
    end
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    #1;

    // Reset state
    chk("rst_outstanding", 32'(outstanding_o), 0);
    chk("rst_err", {31'b0, err_o}, 0);
    chk("rst_out_req", {31'b0, out_req_o}, 0);
    chk("rst_in_gnt", {28'b0, in_gnt_o}, 0);
    chk("rst_r_valid", {28'b0, in_r_valid_o}, 0);
    chk("rst_lrdy", {31'b0, out_lrdy_o}, 1);
    chk("rst_payload_add", out_add_o, addr_of(0));

    // All requesters, master always grants, 1-cycle response latency
    for (int k = 0; k < 8; k++) begin
      cyc(4'hF, 1'b1, k > 0, 32'hD000_0000 + 32'(k - 1), 4'hF,
          k % 4, (k > 0) ? oh((k - 1) % 4) : 4'b0, 32'hD000_0000 + 32'(k - 1));
      chk("p1_outstanding", 32'(outstanding_o), (k == 0) ? 0 : 1);
    end
    cyc(4'h0, 1'b0, 1'b1, 32'hD000_0007, 4'hF, -1, oh(3), 32'hD000_0007);

    // Stalled master: request held on requester 0, then granted
    for (int k = 0; k < 3; k++) begin
      cyc(4'b0101, 1'b0, 1'b0, 32'h0, 4'hF, -1, 4'b0, 32'h0);
      chk("p2_stall_add", out_add_o, addr_of(0));
      chk("p2_stall_req", {31'b0, out_req_o}, 1);
      chk("p2_stall_gnt", {28'b0, in_gnt_o}, 0);
    end
    cyc(4'b0101, 1'b1, 1'b0, 32'h0, 4'hF, 0, 4'b0, 32'h0);
    cyc(4'b0101, 1'b1, 1'b1, 32'hE000_0000, 4'hF, 2, oh(0), 32'hE000_0000);
    // Lock taken on requester 2 (pointer now 3)
    cyc(4'b0100, 1'b0, 1'b1, 32'hE000_0001, 4'hF, -1, oh(2), 32'hE000_0001);
    chk("p2_lock_add0", out_add_o, addr_of(2));
    // Requester 0 joins; without the lock the pointer would pick 0
    cyc(4'b0101, 1'b0, 1'b0, 32'h0, 4'hF, -1, 4'b0, 32'h0);
    chk("p2_lock_add1", out_add_o, addr_of(2));
    cyc(4'b0101, 1'b1, 1'b0, 32'h0, 4'hF, 2, 4'b0, 32'h0);
    cyc(4'h0, 1'b0, 1'b1, 32'hE000_0002, 4'hF, -1, oh(2), 32'hE000_0002);

    // Queue full: pointer at 3, four grants then blocked
    cyc(4'hF, 1'b1, 1'b0, 32'h0, 4'hF, 3, 4'b0, 32'h0);
    cyc(4'hF, 1'b1, 1'b0, 32'h0, 4'hF, 0, 4'b0, 32'h0);
    cyc(4'hF, 1'b1, 1'b0, 32'h0, 4'hF, 1, 4'b0, 32'h0);
    cyc(4'hF, 1'b1, 1'b0, 32'h0, 4'hF, 2, 4'b0, 32'h0);
    cyc(4'hF, 1'b1, 1'b0, 32'h0, 4'hF, -1, 4'b0, 32'h0);
    chk("p3_full_req", {31'b0, out_req_o}, 0);
    chk("p3_full_count", 32'(outstanding_o), 4);
    chk("p3_full_gnt", {28'b0, in_gnt_o}, 0);
    cyc(4'hF, 1'b1, 1'b1, 32'hF000_0000, 4'hF, -1, oh(3), 32'hF000_0000);
    chk("p3_full_pop_req", {31'b0, out_req_o}, 0);
    cyc(4'hF, 1'b1, 1'b0, 32'h0, 4'hF, 3, 4'b0, 32'h0);
    chk("p3_reassert_count", 32'(outstanding_o), 3);
    for (int k = 0; k < 4; k++) begin
      cyc(4'h0, 1'b0, 1'b1, 32'hF000_0001 + 32'(k), 4'hF, -1, oh(k),
          32'hF000_0001 + 32'(k));
    end

    // Response routing with owner backpressure (pointer at 0)
    cyc(4'b0010, 1'b1, 1'b0, 32'h0, 4'hF, 1, 4'b0, 32'h0);
    cyc(4'b1000, 1'b1, 1'b0, 32'h0, 4'hF, 3, 4'b0, 32'h0);
    for (int k = 0; k < 2; k++) begin
      cyc(4'h0, 1'b0, 1'b1, 32'h1111_0001, 4'b1101, -1, 4'b0, 32'h0);
      chk("p4_hold_lrdy", {31'b0, out_lrdy_o}, 0);
      chk("p4_hold_vec", {28'b0, in_r_valid_o}, 32'h2);
      chk("p4_hold_data", in_r_data_o, 32'h1111_0001);
      chk("p4_hold_count", 32'(outstanding_o), 2);
    end
    cyc(4'h0, 1'b0, 1'b1, 32'h1111_0001, 4'hF, -1, oh(1), 32'h1111_0001);
    cyc(4'h0, 1'b0, 1'b1, 32'h3333_0003, 4'hF, -1, oh(3), 32'h3333_0003);

    // Response on an empty queue, with a same-cycle push (pointer at 0)
    cyc(4'b0100, 1'b1, 1'b1, 32'h4444_0000, 4'hF, 2, 4'b0, 32'h0);
    chk("p5_err_noroute", {28'b0, in_r_valid_o}, 0);
    chk("p5_err_before", {31'b0, err_o}, 0);
    chk("p5_empty_lrdy", {31'b0, out_lrdy_o}, 1);
    cyc(4'h0, 1'b0, 1'b0, 32'h0, 4'hF, -1, 4'b0, 32'h0);
    chk("p5_err_set", {31'b0, err_o}, 1);
    chk("p5_no_pop", 32'(outstanding_o), 1);
    cyc(4'h0, 1'b0, 1'b1, 32'h4444_0001, 4'hF, -1, oh(2), 32'h4444_0001);
    cyc(4'h0, 1'b0, 1'b0, 32'h0, 4'hF, -1, 4'b0, 32'h0);
    chk("p5_err_sticky", {31'b0, err_o}, 1);
    chk("p5_drained", 32'(outstanding_o), 0);
    pulse(1'b1);
    chk("p5_clear_err", {31'b0, err_o}, 0);
    // Pointer was 3 before clear; grant going to 0 shows it reset
    cyc(4'hF, 1'b1, 1'b0, 32'h0, 4'hF, 0, 4'b0, 32'h0);
    cyc(4'h0, 1'b0, 1'b1, 32'h5555_0000, 4'hF, -1, oh(0), 32'h5555_0000);

    // Reset with two transactions outstanding (pointer at 1)
    cyc(4'hF, 1'b1, 1'b0, 32'h0, 4'hF, 1, 4'b0, 32'h0);
    cyc(4'hF, 1'b1, 1'b0, 32'h0, 4'hF, 2, 4'b0, 32'h0);
    chk("p6_pre_count", 32'(outstanding_o), 1);
    pulse(1'b0);
    chk("p6_rst_count", 32'(outstanding_o), 0);
    chk("p6_rst_req", {31'b0, out_req_o}, 0);
    chk("p6_rst_r_valid", {28'b0, in_r_valid_o}, 0);
    cyc(4'hF, 1'b1, 1'b0, 32'h0, 4'hF, 0, 4'b0, 32'h0);
    cyc(4'h0, 1'b0, 1'b1, 32'h6666_0000, 4'hF, -1, oh(0), 32'h6666_0000);
    cyc(4'h0, 1'b0, 1'b0, 32'h0, 4'hF, -1, 4'b0, 32'h0);
    chk("p6_final_count", 32'(outstanding_o), 0);
    chk("p6_final_err", {31'b0, err_o}, 0);

    chk("grant_q_left", 32'(q_gnt.size()), 0);
    chk("rsp_q_left", 32'(q_rsp.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
